// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART datapath.
// Synchronises rx, detects the start edge, times mid-bit sampling with a
// baud counter and issues one-cycle strobes to the SIPO / parity datapath.
// Handshake: there is no back-pressure; every strobe and status pulse
// (data_shift, par_load, par_gen, rx_valid, frame_err) is a single-cycle
// qualifier that the datapath and host must consume in that same cycle.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_EN    = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic rx,
   input  logic par_check,
   output logic data_in,
   output logic data_shift,
   output logic par_load,
   output logic par_gen,
   output logic parity,
   output logic start_bit,
   output logic stop_bit,
   output logic rx_valid,
   output logic frame_err,
   output logic parity_err,
   output logic busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_TERM  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic            stop_q, stop_d;
   logic            sync1_q, rx_s, rx_s_d;
   logic            fall;

   // A falling edge is only meaningful while idle; busy states ignore it.
   assign fall = rx_s_d & ~rx_s;
   assign busy = (state_q != S_IDLE);

   // Two-flop synchroniser plus a delay flop for edge detection; idle high.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s    <= sync1_q;
         rx_s_d  <= rx_s;
      end
   end

   // State, baud counter, bit index and latched stop sample.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
      end
   end

   // Parity status: cleared at start detect, loaded from the datapath's
   // registered compare on the first STOP cycle, then held.
   always_ff @(posedge clock) begin
      if (!reset) begin
         parity_err <= 1'b0;
      end else if (state_q == S_IDLE && fall) begin
         parity_err <= 1'b0;
      end else if (PARITY_EN != 0 && state_q == S_STOP && cnt_q == '0) begin
         parity_err <= ~par_check;
      end
   end

   // Next-state and strobe decode from state plus baud counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      stop_d     = stop_q;
      data_in    = 1'b0;
      data_shift = 1'b0;
      par_load   = 1'b0;
      par_gen    = 1'b0;
      parity     = 1'b0;
      start_bit  = 1'b1;
      stop_bit   = 1'b0;
      rx_valid   = 1'b0;
      frame_err  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (fall) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_TERM) begin
               start_bit = rx_s;
               cnt_d     = '0;
               bit_d     = '0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_TERM) begin
               data_in    = rx_s;
               data_shift = 1'b1;
               cnt_d      = '0;
               bit_d      = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            // The eighth shift has landed, so the SIPO word is complete here.
            if (cnt_q == '0) par_load = 1'b1;
            if (cnt_q == BIT_TERM) begin
               parity  = rx_s;
               par_gen = 1'b1;
               cnt_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_TERM) begin
               stop_bit = rx_s;
               stop_d   = rx_s;
               cnt_d    = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            rx_valid  = stop_q;
            frame_err = ~stop_q;
            cnt_d     = '0;
            state_d   = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: drives serial frames into two controllers (with and
// without parity) and checks strobes, sampled bits and status pulses
// against expectations derived from the frame contents.
module tb_uart_rx_ctrl;

   localparam int CPB = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] rx_w;
   logic [1:0] pc_w = 2'b01;
   logic [1:0] data_in_w, data_shift_w, par_load_w, par_gen_w, parity_w;
   logic [1:0] start_bit_w, stop_bit_w, rx_valid_w, frame_err_w, parity_err_w, busy_w;

   int checks;
   int errors;

   // Clock generation.
   always #5 clock = ~clock;

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_par (
      .clock(clock), .reset(reset), .rx(rx_w[0]), .par_check(pc_w[0]),
      .data_in(data_in_w[0]), .data_shift(data_shift_w[0]), .par_load(par_load_w[0]),
      .par_gen(par_gen_w[0]), .parity(parity_w[0]), .start_bit(start_bit_w[0]),
      .stop_bit(stop_bit_w[0]), .rx_valid(rx_valid_w[0]), .frame_err(frame_err_w[0]),
      .parity_err(parity_err_w[0]), .busy(busy_w[0])
   );

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_nopar (
      .clock(clock), .reset(reset), .rx(rx_w[1]), .par_check(pc_w[1]),
      .data_in(data_in_w[1]), .data_shift(data_shift_w[1]), .par_load(par_load_w[1]),
      .par_gen(par_gen_w[1]), .parity(parity_w[1]), .start_bit(start_bit_w[1]),
      .stop_bit(stop_bit_w[1]), .rx_valid(rx_valid_w[1]), .frame_err(frame_err_w[1]),
      .parity_err(parity_err_w[1]), .busy(busy_w[1])
   );

   // Observation state per instance, sampled on the falling clock edge.
   int         cyc;
   int         clr_gen, seen_gen;
   int         n_shift[2], n_load[2], n_gen[2], n_valid[2], n_ferr[2];
   int         n_start0[2], n_stop1[2], n_busy[2], n_multi[2], gap_bad[2], last_shift[2];
   logic [7:0] word[2];
   logic       got_par[2], pe_valid[2], pe_first[2];

   // Monitor plus a minimal datapath: SIPO word and registered parity compare.
   always @(negedge clock) begin
      cyc = cyc + 1;
      if (seen_gen != clr_gen) begin
         seen_gen = clr_gen;
         for (int k = 0; k < 2; k++) begin
            n_shift[k] = 0; n_load[k] = 0; n_gen[k] = 0; n_valid[k] = 0; n_ferr[k] = 0;
            n_start0[k] = 0; n_stop1[k] = 0; n_busy[k] = 0; n_multi[k] = 0; gap_bad[k] = 0;
            last_shift[k] = -1; word[k] = 8'h00;
            got_par[k] = 1'bx; pe_valid[k] = 1'bx; pe_first[k] = 1'b1;
         end
      end
      for (int k = 0; k < 2; k++) begin
         int nstr;
         nstr = int'(data_shift_w[k]) + int'(par_load_w[k]) + int'(par_gen_w[k])
              + int'(rx_valid_w[k]) + int'(frame_err_w[k]);
         if (nstr > 1) n_multi[k]++;
         if (busy_w[k] === 1'b1) n_busy[k]++;
         if (start_bit_w[k] === 1'b0) n_start0[k]++;
         if (stop_bit_w[k] === 1'b1) n_stop1[k]++;
         if (data_shift_w[k] === 1'b1) begin
            if (last_shift[k] < 0) pe_first[k] = parity_err_w[k];
            else if (cyc - last_shift[k] != CPB) gap_bad[k]++;
            last_shift[k] = cyc;
            word[k] = {data_in_w[k], word[k][7:1]};
            n_shift[k]++;
         end
         if (par_load_w[k] === 1'b1) n_load[k]++;
         if (par_gen_w[k] === 1'b1) begin
            n_gen[k]++;
            got_par[k] = parity_w[k];
            if (k == 0) pc_w[0] = (parity_w[0] == ^word[0]);
         end
         if (rx_valid_w[k] === 1'b1) begin
            n_valid[k]++;
            pe_valid[k] = parity_err_w[k];
            last_shift[k] = -1;
         end
         if (frame_err_w[k] === 1'b1) begin
            n_ferr[k]++;
            last_shift[k] = -1;
         end
      end
      pc_w[1] = 1'b0;
   end

   task automatic mon_clear();
      clr_gen++;
      @(negedge clock);
   endtask

   task automatic drive_bit(input int k, input logic v, input int n);
      rx_w[k] = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_frame(input int k, input logic [7:0] b, input logic has_par,
                             input logic pbit, input logic sbit, input logic idle_lvl);
      drive_bit(k, 1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(k, b[i], CPB);
      if (has_par) drive_bit(k, pbit, CPB);
      drive_bit(k, sbit, CPB);
      rx_w[k] = idle_lvl;
   endtask

   task automatic wait_idle(input int k, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * CPB; i++) begin
         if (busy_w[k] === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx_w  = 2'b11;
      repeat (3) @(negedge clock);
      checks++;
      if (busy_w !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", busy_w); end
      checks++;
      if (parity_err_w !== 2'b00) begin errors++; $display("FAIL reset_perr got %b exp 00", parity_err_w); end
      checks++;
      if (start_bit_w !== 2'b11 || stop_bit_w !== 2'b00) begin
         errors++; $display("FAIL reset_samples got start %b stop %b exp 11 00", start_bit_w, stop_bit_w);
      end
      checks++;
      if ((data_shift_w | par_load_w | par_gen_w | rx_valid_w | frame_err_w) !== 2'b00) begin
         errors++; $display("FAIL reset_strobes got nonzero strobe exp 00");
      end
      reset = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_parity_ok();
      logic ok;
      mon_clear();
      send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_idle(0, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL pok_timeout got busy exp idle"); end
      checks++;
      if (word[0] !== 8'hA5) begin errors++; $display("FAIL pok_word got %h exp a5", word[0]); end
      checks++;
      if (n_shift[0] !== 8 || gap_bad[0] !== 0) begin
         errors++; $display("FAIL pok_shifts got %0d gaps_bad %0d exp 8 0", n_shift[0], gap_bad[0]);
      end
      checks++;
      if (n_load[0] !== 1 || n_gen[0] !== 1 || got_par[0] !== 1'b0) begin
         errors++; $display("FAIL pok_parity got load %0d gen %0d par %b exp 1 1 0", n_load[0], n_gen[0], got_par[0]);
      end
      checks++;
      if (n_valid[0] !== 1 || n_ferr[0] !== 0 || parity_err_w[0] !== 1'b0) begin
         errors++; $display("FAIL pok_status got valid %0d ferr %0d perr %b exp 1 0 0", n_valid[0], n_ferr[0], parity_err_w[0]);
      end
      checks++;
      if (n_start0[0] !== 1 || n_stop1[0] !== 1 || n_multi[0] !== 0) begin
         errors++; $display("FAIL pok_samples got start0 %0d stop1 %0d multi %0d exp 1 1 0", n_start0[0], n_stop1[0], n_multi[0]);
      end
   endtask

   task automatic test_parity_bad();
      logic ok;
      mon_clear();
      send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_idle(0, ok);
      repeat (3) @(negedge clock);
      checks++;
      if (n_valid[0] !== 1 || got_par[0] !== 1'b1) begin
         errors++; $display("FAIL pbad_valid got valid %0d par %b exp 1 1", n_valid[0], got_par[0]);
      end
      checks++;
      if (pe_valid[0] !== 1'b1) begin errors++; $display("FAIL pbad_perr_done got %b exp 1", pe_valid[0]); end
      checks++;
      if (parity_err_w[0] !== 1'b1 || ok !== 1'b1) begin
         errors++; $display("FAIL pbad_perr_idle got %b idle %b exp 1 1", parity_err_w[0], ok);
      end
   endtask

   task automatic test_frame_err_break();
      logic ok;
      mon_clear();
      send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_idle(0, ok);
      checks++;
      if (n_ferr[0] !== 1 || n_valid[0] !== 0 || n_stop1[0] !== 0) begin
         errors++; $display("FAIL ferr_pulse got ferr %0d valid %0d stop1 %0d exp 1 0 0", n_ferr[0], n_valid[0], n_stop1[0]);
      end
      checks++;
      if (pe_first[0] !== 1'b0 || word[0] !== 8'h3C) begin
         errors++; $display("FAIL ferr_clear got perr %b word %h exp 0 3c", pe_first[0], word[0]);
      end
      mon_clear();
      drive_bit(0, 1'b0, 3 * CPB);
      checks++;
      if (n_busy[0] !== 0) begin errors++; $display("FAIL break_idle got busy %0d exp 0", n_busy[0]); end
      drive_bit(0, 1'b1, CPB);
      mon_clear();
      send_frame(0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_idle(0, ok);
      checks++;
      if (n_valid[0] !== 1 || word[0] !== 8'h55) begin
         errors++; $display("FAIL break_next got valid %0d word %h exp 1 55", n_valid[0], word[0]);
      end
   endtask

   task automatic test_glitch();
      mon_clear();
      drive_bit(0, 1'b0, 2);
      rx_w[0] = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL glitch_start got busy %b exp 1", busy_w[0]); end
      repeat (CPB) @(negedge clock);
      checks++;
      if (busy_w[0] !== 1'b0 || n_busy[0] !== CPB / 2) begin
         errors++; $display("FAIL glitch_abort got busy %b cycles %0d exp 0 %0d", busy_w[0], n_busy[0], CPB / 2);
      end
      checks++;
      if (n_shift[0] + n_load[0] + n_gen[0] + n_valid[0] + n_ferr[0] + n_start0[0] !== 0) begin
         errors++; $display("FAIL glitch_strobes got %0d exp 0",
                            n_shift[0] + n_load[0] + n_gen[0] + n_valid[0] + n_ferr[0] + n_start0[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      logic       ok;
      b = 8'h5A;
      mon_clear();
      drive_bit(0, 1'b0, CPB);
      for (int i = 0; i < 3; i++) drive_bit(0, b[i], CPB);
      drive_bit(0, b[3], CPB / 2);
      reset   = 1'b0;
      rx_w[0] = 1'b1;
      @(negedge clock);
      checks++;
      if (busy_w[0] !== 1'b0 || start_bit_w[0] !== 1'b1 || data_shift_w[0] !== 1'b0) begin
         errors++; $display("FAIL rstmid_state got busy %b start %b shift %b exp 0 1 0",
                            busy_w[0], start_bit_w[0], data_shift_w[0]);
      end
      reset = 1'b1;
      repeat (12 * CPB) @(negedge clock);
      checks++;
      if (n_valid[0] !== 0 || n_ferr[0] !== 0 || busy_w[0] !== 1'b0) begin
         errors++; $display("FAIL rstmid_nopulse got valid %0d ferr %0d busy %b exp 0 0 0", n_valid[0], n_ferr[0], busy_w[0]);
      end
      mon_clear();
      send_frame(0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_idle(0, ok);
      checks++;
      if (n_valid[0] !== 1 || word[0] !== 8'h55 || n_shift[0] !== 8) begin
         errors++; $display("FAIL rstmid_next got valid %0d word %h shifts %0d exp 1 55 8", n_valid[0], word[0], n_shift[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic ok;
      mon_clear();
      send_frame(1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (n_valid[1] !== 1 || word[1] !== 8'h01 || n_shift[1] !== 8) begin
         errors++; $display("FAIL b2b_first got valid %0d word %h shifts %0d exp 1 01 8", n_valid[1], word[1], n_shift[1]);
      end
      drive_bit(1, 1'b1, CPB);
      send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_idle(1, ok);
      checks++;
      if (n_valid[1] !== 2 || word[1] !== 8'hFF || n_shift[1] !== 16 || gap_bad[1] !== 0) begin
         errors++; $display("FAIL b2b_second got valid %0d word %h shifts %0d gaps_bad %0d exp 2 ff 16 0",
                            n_valid[1], word[1], n_shift[1], gap_bad[1]);
      end
      checks++;
      if (n_load[1] !== 0 || n_gen[1] !== 0 || parity_err_w[1] !== 1'b0) begin
         errors++; $display("FAIL b2b_noparity got load %0d gen %0d perr %b exp 0 0 0", n_load[1], n_gen[1], parity_err_w[1]);
      end
      checks++;
      if (n_start0[1] !== 2 || n_stop1[1] !== 2 || n_ferr[1] !== 0 || n_multi[1] !== 0) begin
         errors++; $display("FAIL b2b_samples got start0 %0d stop1 %0d ferr %0d multi %0d exp 2 2 0 0",
                            n_start0[1], n_stop1[1], n_ferr[1], n_multi[1]);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         int         k;
         logic [7:0] b;
         logic       hp, pbit, sbit, exp_pe, ok;
         k      = int'($urandom_range(0, 1));
         b      = 8'($urandom_range(0, 255));
         hp     = (k == 0);
         pbit   = (^b) ^ ($urandom_range(0, 2) == 0);
         sbit   = ($urandom_range(0, 3) != 0);
         exp_pe = hp && (pbit != ^b);
         mon_clear();
         send_frame(k, b, hp, pbit, sbit, 1'b1);
         wait_idle(k, ok);
         checks++;
         if (ok !== 1'b1 || word[k] !== b || n_shift[k] !== 8 || gap_bad[k] !== 0) begin
            errors++; $display("FAIL rand_data inst %0d got word %h shifts %0d gaps_bad %0d idle %b exp %h 8 0 1",
                               k, word[k], n_shift[k], gap_bad[k], ok, b);
         end
         checks++;
         if (n_valid[k] !== int'(sbit) || n_ferr[k] !== int'(!sbit) || n_stop1[k] !== int'(sbit)) begin
            errors++; $display("FAIL rand_stop inst %0d got valid %0d ferr %0d stop1 %0d exp stop %b",
                               k, n_valid[k], n_ferr[k], n_stop1[k], sbit);
         end
         checks++;
         if (n_load[k] !== int'(hp) || n_gen[k] !== int'(hp) || parity_err_w[k] !== exp_pe) begin
            errors++; $display("FAIL rand_parity inst %0d got load %0d gen %0d perr %b exp %0d %0d %b",
                               k, n_load[k], n_gen[k], parity_err_w[k], hp, hp, exp_pe);
         end
         checks++;
         if (n_multi[k] !== 0 || n_start0[k] !== 1) begin
            errors++; $display("FAIL rand_strobes inst %0d got multi %0d start0 %0d exp 0 1", k, n_multi[k], n_start0[k]);
         end
         drive_bit(k, 1'b1, int'($urandom_range(1, 3)) * CPB);
      end
   endtask

   // Bound on total run time.
   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   // Test sequence and final report.
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_parity_ok();
      test_parity_bad();
      test_frame_err_break();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
